// File: rtl/delay_window_monitor.sv
// delay_window_monitor
// Runtime checker for the bounded-delay implication a |-> ##[MIN_DLY:MAX_DLY] b.
// Each sampled a opens one obligation. The obligation rides a shift vector
// until a b inside its window discharges it, or until it falls off the end
// unmet. Reset acts as the disable: it drops every open obligation without
// reporting a fail.
module delay_window_monitor #(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         a,
    input  logic                         b,
    output logic                         pass,
    output logic                         fail,
    output logic                         fail_sticky,
    output logic [$clog2(MAX_DLY+1)-1:0] open_cnt,
    output logic [CNT_W-1:0]             pass_count,
    output logic [CNT_W-1:0]             fail_count
);

    localparam int OW    = $clog2(MAX_DLY + 1);
    localparam int SUM_W = ((CNT_W > OW) ? CNT_W : OW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Number of set bits in an obligation-shaped vector.
    function automatic logic [OW-1:0] popcount(input logic [MAX_DLY:1] v);
        logic [OW-1:0] cnt;
        cnt = {OW{1'b0}};
        for (int i = 1; i <= MAX_DLY; i++) begin
            cnt = cnt + OW'(v[i]);
        end
        return cnt;
    endfunction

    // obl_r[k] = 1: an obligation opened k edges ago is still waiting for b.
    logic [MAX_DLY:1] obl_r;
    logic             pass_r;
    logic             fail_r;
    logic             fail_sticky_r;
    logic [OW-1:0]    open_cnt_r;
    logic [CNT_W-1:0] pass_count_r;
    logic [CNT_W-1:0] fail_count_r;

    logic [MAX_DLY:1] hit_s;
    logic [MAX_DLY:1] obl_next_s;
    logic             expire_s;
    logic [OW-1:0]    hit_cnt_s;
    logic [SUM_W-1:0] pass_sum_s;
    logic [CNT_W-1:0] pass_count_next_s;
    logic [CNT_W-1:0] fail_count_next_s;

    // Decide which obligations b discharges, which one expires, and advance the vector.
    always_comb begin
        hit_s      = {MAX_DLY{1'b0}};
        obl_next_s = {MAX_DLY{1'b0}};
        for (int k = 1; k <= MAX_DLY; k++) begin
            if (k >= MIN_DLY) begin
                hit_s[k] = obl_r[k] & b;
            end else begin
                // Too early: b does not count and the obligation stays open.
                hit_s[k] = 1'b0;
            end
        end
        expire_s      = obl_r[MAX_DLY] & ~b;
        obl_next_s[1] = a;
        // The entry at MAX_DLY has no successor, so it always leaves here.
        for (int k = 1; k < MAX_DLY; k++) begin
            obl_next_s[k+1] = obl_r[k] & ~hit_s[k];
        end
    end

    // Saturating counter updates: add at full width, then clamp.
    always_comb begin
        hit_cnt_s  = popcount(hit_s);
        pass_sum_s = SUM_W'(pass_count_r) + SUM_W'(hit_cnt_s);
        if (pass_sum_s > SUM_W'(CNT_MAX)) begin
            pass_count_next_s = CNT_MAX;
        end else begin
            pass_count_next_s = pass_sum_s[CNT_W-1:0];
        end
        if (expire_s && (fail_count_r != CNT_MAX)) begin
            fail_count_next_s = fail_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            fail_count_next_s = fail_count_r;
        end
    end

    // Obligation vector and registered report outputs; reset drops everything silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            obl_r         <= {MAX_DLY{1'b0}};
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            fail_sticky_r <= 1'b0;
            open_cnt_r    <= {OW{1'b0}};
            pass_count_r  <= {CNT_W{1'b0}};
            fail_count_r  <= {CNT_W{1'b0}};
        end else begin
            obl_r         <= obl_next_s;
            pass_r        <= |hit_s;
            fail_r        <= expire_s;
            fail_sticky_r <= fail_sticky_r | expire_s;
            open_cnt_r    <= popcount(obl_next_s);
            pass_count_r  <= pass_count_next_s;
            fail_count_r  <= fail_count_next_s;
        end
    end

    assign pass        = pass_r;
    assign fail        = fail_r;
    assign fail_sticky = fail_sticky_r;
    assign open_cnt    = open_cnt_r;
    assign pass_count  = pass_count_r;
    assign fail_count  = fail_count_r;

endmodule
